alu_unit: RTL and testbench

//  Datapath ALU of the picoMIPS core. Output result is combinational from a, b and func.

---
 rtl/cpuConfig.sv | 19 +
 rtl/alu_fxmul.sv | 20 ++
 rtl/alu_unit.sv | 87 ++++++++
 tb/tb_alu_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpuConfig.sv
// Shared configuration for the picoMIPS datapath: widths, Q-format constant and ALU op encoding.
package cpuConfig;

    localparam int N         = 8;
    localparam int A_SIZE    = 3;
    localparam int FRAC_BITS = N - 1;

    typedef enum logic [A_SIZE-1:0] {
        ALU_A   = A_SIZE'(0),
        ALU_B   = A_SIZE'(1),
        ALU_ADD = A_SIZE'(2),
        ALU_SUB = A_SIZE'(3),
        ALU_MUL = A_SIZE'(4),
        ALU_AND = A_SIZE'(5),
        ALU_OR  = A_SIZE'(6),
        ALU_XOR = A_SIZE'(7)
    } aluFunc_t;

endpackage

// File: rtl/alu_fxmul.sv
// Fixed-point multiply: signed Q1.(N-1) fraction times signed integer, floored back to N bits.
module alu_fxmul
    import cpuConfig::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] product
);

    logic signed [2*N-1:0] full_prod;

    assign full_prod = $signed(a) * $signed(b);

    // Dropping the low FRAC_BITS bits of a two's-complement value is a floor, not a truncation toward zero.
    assign product = full_prod[2*N-2:FRAC_BITS];

    logic unused_prod_bits;
    assign unused_prod_bits = ^{full_prod[2*N-1], full_prod[FRAC_BITS-1:0]};

endmodule

// File: rtl/alu_unit.sv
// picoMIPS datapath ALU: combinational result, registered Z/N/C flags.
// Flag registers are only built when ALU_FLAGS_EN is defined; otherwise the flags read as 0.
module alu_unit
    import cpuConfig::*;
(
    input  logic              clk,
    input  logic              nReset,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic [A_SIZE-1:0] func,
    input  logic              flagEn,
    output logic [N-1:0]      result,
    output logic              zFlag,
    output logic              nFlag,
    output logic              cFlag
);

    aluFunc_t     op;
    logic [N:0]   add_sum;
    logic [N-1:0] mul_res;
    logic [N-1:0] alu_res;
    logic         carry;

    assign op      = aluFunc_t'(func);
    assign add_sum = {1'b0, a} + {1'b0, b};

    alu_fxmul u_fxmul (
        .a       (a),
        .b       (b),
        .product (mul_res)
    );

    always_comb begin
        alu_res = '0;
        carry   = 1'b0;
        case (op)
            ALU_A:   alu_res = a;
            ALU_B:   alu_res = b;
            ALU_ADD: begin
                alu_res = add_sum[N-1:0];
                carry   = add_sum[N];
            end
            ALU_SUB: begin
                alu_res = a - b;
                carry   = (a >= b);
            end
            ALU_MUL: alu_res = mul_res;
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_XOR: alu_res = a ^ b;
            default: begin
                alu_res = '0;
                carry   = 1'b0;
            end
        endcase
    end

    assign result = alu_res;

`ifdef ALU_FLAGS_EN
    logic z_reg, n_reg, c_reg;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            z_reg <= 1'b0;
            n_reg <= 1'b0;
            c_reg <= 1'b0;
        end else if (flagEn) begin
            z_reg <= (alu_res == '0);
            n_reg <= alu_res[N-1];
            c_reg <= carry;
        end
    end

    assign zFlag = z_reg;
    assign nFlag = n_reg;
    assign cFlag = c_reg;
`else
    assign zFlag = 1'b0;
    assign nFlag = 1'b0;
    assign cFlag = 1'b0;

    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{clk, nReset, flagEn, carry};
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: arithmetic reference model plus hand-computed pinning vectors.
module tb_alu_unit;

`ifdef ALU_FLAGS_EN
    localparam logic FLAGS_BUILT = 1'b1;
`else
    localparam logic FLAGS_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nReset = 1'b1;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [2:0] func = 3'd0;
    logic       flagEn = 1'b0;
    logic [7:0] result;
    logic       zFlag, nFlag, cFlag;

    int errors = 0;
    int checks = 0;

    logic ez = 1'b0, en = 1'b0, ec = 1'b0;

    alu_unit dut (
        .clk    (clk),
        .nReset (nReset),
        .a      (a),
        .b      (b),
        .func   (func),
        .flagEn (flagEn),
        .result (result),
        .zFlag  (zFlag),
        .nFlag  (nFlag),
        .cFlag  (cFlag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {carry, result} straight from the arithmetic definition of each op.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] f);
        int s, sx, sy, p;
        logic [7:0] r;
        logic       c;
        r = 8'd0;
        c = 1'b0;
        sx = $signed(x);
        sy = $signed(y);
        case (f)
            3'd0: r = x;
            3'd1: r = y;
            3'd2: begin
                s = int'(x) + int'(y);
                r = s[7:0];
                c = (s > 255);
            end
            3'd3: begin
                s = int'(x) - int'(y);
                r = s[7:0];
                c = (int'(x) >= int'(y));
            end
            3'd4: begin
                p = (sx * sy) >>> 7;
                r = p[7:0];
            end
            3'd5: r = x & y;
            3'd6: r = x | y;
            default: r = x ^ y;
        endcase
        return {c, r};
    endfunction

    function automatic logic fl(input logic v);
        return v & FLAGS_BUILT;
    endfunction

    // Compare process: result checked every cycle, flags checked just after every edge.
    initial begin
        logic [8:0] m;
        forever begin
            @(posedge clk);
            m = model(a, b, func);
            chk("result", 32'(result), 32'(m[7:0]));
            if (!nReset) begin
                ez = 1'b0; en = 1'b0; ec = 1'b0;
            end else if (flagEn && FLAGS_BUILT) begin
                ez = (m[7:0] == 8'd0);
                en = m[7];
                ec = m[8];
            end
            #1;
            chk("zFlag", 32'(zFlag), 32'(ez));
            chk("nFlag", 32'(nFlag), 32'(en));
            chk("cFlag", 32'(cFlag), 32'(ec));
        end
    end

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [2:0] f, input logic e);
        @(negedge clk);
        a = x; b = y; func = f; flagEn = e;
        #1;
    endtask

    task automatic chk_flags(input string name, input logic z, input logic n, input logic c);
        chk({name, "_z"}, 32'(zFlag), 32'(z));
        chk({name, "_n"}, 32'(nFlag), 32'(n));
        chk({name, "_c"}, 32'(cFlag), 32'(c));
    endtask

    logic [2:0] bw_func [5] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
    logic [7:0] bw_exp  [5] = '{8'hA5, 8'h3C, 8'h24, 8'hBD, 8'h99};

    initial begin
        #1 nReset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        nReset = 1'b1;

        drive(8'd10, 8'd5, 3'd2, 1'b1);
        chk("add_10_5", 32'(result), 32'd15);
        @(posedge clk); #2;
        chk_flags("add_10_5", 1'b0, 1'b0, 1'b0);

        drive(8'b0110_0000, 8'd6, 3'd4, 1'b0);
        chk("mul_0p75_6", 32'(result), 32'h04);
        drive(8'b1100_0000, 8'd5, 3'd4, 1'b0);
        chk("mul_m0p5_5", 32'(result), 32'hFD);

        drive(8'hFF, 8'd1, 3'd2, 1'b1);
        chk("add_ff_1", 32'(result), 32'h00);
        @(posedge clk); #2;
        chk_flags("add_ff_1", fl(1'b1), 1'b0, fl(1'b1));

        drive(8'd3, 8'd5, 3'd3, 1'b1);
        chk("sub_3_5", 32'(result), 32'hFE);
        @(posedge clk); #2;
        chk_flags("sub_3_5", 1'b0, fl(1'b1), 1'b0);

        for (int i = 0; i < 3; i++)
            drive(8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
        @(posedge clk); #2;
        chk_flags("hold", 1'b0, fl(1'b1), 1'b0);

        // Asynchronous clear between edges.
        @(negedge clk);
        #2 nReset = 1'b0;
        #1;
        chk_flags("async_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nReset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(8'hA5, 8'h3C, bw_func[i], 1'b1);
            chk($sformatf("bitwise_f%0d", bw_func[i]), 32'(result), 32'(bw_exp[i]));
        end

        for (int i = 0; i < 400; i++)
            drive(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
